// File: rtl/iwanna_hpi_pkg.sv
// Shared types and constants for the HPI I/O sequencer: FSM state encoding,
// HPI register addresses and the phase counter width.
package iwanna_hpi_pkg;

  localparam int unsigned PHASE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } hpi_state_t;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

endpackage

// File: rtl/iwanna_hpi_phase_cnt.sv
// Phase length down-counter: load (length - 1), decrement each cycle,
// report zero so the sequencer knows the current phase ends this cycle.
module iwanna_hpi_phase_cnt
  import iwanna_hpi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [PHASE_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iwanna_hpi_io_seq.sv
// Avalon-MM slave to Cypress HPI bus sequencer: one access at a time through
// SETUP / STROBE / HOLD phases, all HPI pins driven straight from flops.
module iwanna_hpi_io_seq
  import iwanna_hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic [15:0] readdata,
  output logic        readdatavalid,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
);

  localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] STROBE_LD = PHASE_W'(STROBE_CYC - 1);
  localparam logic [PHASE_W-1:0] HOLD_LD   = PHASE_W'(HOLD_CYC - 1);

  hpi_state_t         state;
  logic               dir_write;
  logic               accept;
  logic               cnt_load;
  logic [PHASE_W-1:0] cnt_val;
  logic               cnt_dec;
  logic               cnt_zero;

  assign waitrequest = (state != ST_IDLE);
  assign accept      = (state == ST_IDLE) && (read || write);
  assign cnt_dec     = (state != ST_IDLE);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE:   if (accept)   begin cnt_load = 1'b1; cnt_val = SETUP_LD;  end
      ST_SETUP:  if (cnt_zero) begin cnt_load = 1'b1; cnt_val = STROBE_LD; end
      ST_STROBE: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = HOLD_LD;   end
      default:   ;
    endcase
  end

  iwanna_hpi_phase_cnt u_phase_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Each HPI pin is set/cleared on the edge that enters/leaves its phase,
  // so the pins themselves are flops and cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      dir_write     <= 1'b0;
      otg_cs_n      <= 1'b1;
      otg_rd_n      <= 1'b1;
      otg_wr_n      <= 1'b1;
      otg_data_oe   <= 1'b0;
      otg_addr      <= '0;
      otg_data_out  <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_SETUP;
            dir_write   <= write;
            otg_cs_n    <= 1'b0;
            otg_addr    <= address;
            otg_data_oe <= write;
            if (write) otg_data_out <= writedata;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state    <= ST_STROBE;
            otg_rd_n <= dir_write;
            otg_wr_n <= !dir_write;
          end
        end
        ST_STROBE: begin
          if (cnt_zero) begin
            state    <= ST_HOLD;
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            if (!dir_write) begin
              readdata      <= otg_data_in;
              readdatavalid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state       <= ST_IDLE;
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iwanna_hpi_io_seq.sv
// Directed bench for the HPI sequencer: per-cycle traces of the HPI pins are
// recorded after each access and compared against hand-derived cycle windows.
module tb_iwanna_hpi_io_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read, write;
  logic [15:0] writedata;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        otg_cs_n, otg_rd_n, otg_wr_n;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;

  // second instance with minimum phase lengths
  logic [1:0]  f_address;
  logic        f_read, f_write;
  logic [15:0] f_writedata;
  logic        f_waitrequest;
  logic [15:0] f_readdata;
  logic        f_readdatavalid;
  logic        f_cs_n, f_rd_n, f_wr_n;
  logic [1:0]  f_addr;
  logic [15:0] f_data_out;
  logic        f_data_oe;

  int total = 0;
  int bad   = 0;

  logic        t_cs [0:31], t_rd [0:31], t_wr [0:31], t_oe [0:31], t_wait [0:31], t_rdv [0:31];
  logic [1:0]  t_addr  [0:31];
  logic [15:0] t_dout  [0:31];
  logic [15:0] t_rdata [0:31];

  always #5 clk = ~clk;

  iwanna_hpi_io_seq #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n),
    .otg_wr_n(otg_wr_n), .otg_addr(otg_addr), .otg_data_out(otg_data_out),
    .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
  );

  iwanna_hpi_io_seq #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
    .clk(clk), .reset(reset), .address(f_address), .read(f_read), .write(f_write),
    .writedata(f_writedata), .waitrequest(f_waitrequest), .readdata(f_readdata),
    .readdatavalid(f_readdatavalid), .otg_cs_n(f_cs_n), .otg_rd_n(f_rd_n),
    .otg_wr_n(f_wr_n), .otg_addr(f_addr), .otg_data_out(f_data_out),
    .otg_data_oe(f_data_oe), .otg_data_in(16'h0000)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Called in cycle 0 (request already presented); records cycles 1..n.
  // At cycle sw_c the request becomes a read of sw_a; at drop_c it is removed.
  task automatic run(input int n, input int din_lo, input int din_hi, input logic [15:0] din_v,
                     input int sw_c, input logic [1:0] sw_a, input int drop_c);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == sw_c) begin
        read = 1'b1; write = 1'b0; address = sw_a; writedata = 16'hAAAA;
      end
      if (c == drop_c) begin
        read = 1'b0; write = 1'b0;
      end
      otg_data_in = in_rng(c, din_lo, din_hi) ? din_v : 16'h5555;
      t_cs[c] = otg_cs_n; t_rd[c] = otg_rd_n; t_wr[c] = otg_wr_n;
      t_oe[c] = otg_data_oe; t_wait[c] = waitrequest; t_rdv[c] = readdatavalid;
      t_addr[c] = otg_addr; t_dout[c] = otg_data_out; t_rdata[c] = readdata;
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    otg_data_in = 16'h5555;
    f_address = '0; f_read = 1'b0; f_write = 1'b0; f_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cs_n", otg_cs_n, 1'b1);
    chk("rst.rd_n", otg_rd_n, 1'b1);
    chk("rst.wr_n", otg_wr_n, 1'b1);
    chk("rst.oe", otg_data_oe, 1'b0);
    chk("rst.addr", otg_addr, 2'd0);
    chk("rst.dout", otg_data_out, 16'h0000);
    chk("rst.rdata", readdata, 16'h0000);
    chk("rst.rdv", readdatavalid, 1'b0);
    chk("rst.wait", waitrequest, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // A: write 0x1234 to ADDRESS register
    write = 1'b1; address = 2'd2; writedata = 16'h1234;
    run(10, 0, -1, 16'h0, 0, 2'd0, 1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("A.cs_n@%0d", c), t_cs[c], !in_rng(c, 1, 8));
      chk($sformatf("A.wr_n@%0d", c), t_wr[c], !in_rng(c, 3, 6));
      chk($sformatf("A.rd_n@%0d", c), t_rd[c], 1'b1);
      chk($sformatf("A.oe@%0d", c), t_oe[c], in_rng(c, 1, 8));
      chk($sformatf("A.wait@%0d", c), t_wait[c], in_rng(c, 1, 8));
      chk($sformatf("A.rdv@%0d", c), t_rdv[c], 1'b0);
      if (in_rng(c, 1, 8)) begin
        chk($sformatf("A.addr@%0d", c), t_addr[c], 2'd2);
        chk($sformatf("A.dout@%0d", c), t_dout[c], 16'h1234);
      end
    end
    chk("A.rdata", t_rdata[10], 16'h0000);

    // B: read DATA register, bus drives 0xBEEF only during strobe
    read = 1'b1; address = 2'd0;
    run(10, 3, 6, 16'hBEEF, 0, 2'd0, 1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("B.cs_n@%0d", c), t_cs[c], !in_rng(c, 1, 8));
      chk($sformatf("B.rd_n@%0d", c), t_rd[c], !in_rng(c, 3, 6));
      chk($sformatf("B.wr_n@%0d", c), t_wr[c], 1'b1);
      chk($sformatf("B.oe@%0d", c), t_oe[c], 1'b0);
      chk($sformatf("B.rdv@%0d", c), t_rdv[c], c == 7);
    end
    chk("B.rdata@6", t_rdata[6], 16'h0000);
    chk("B.rdata@7", t_rdata[7], 16'hBEEF);

    // C: write, then a read held asserted during occupancy (new addr/data ignored)
    write = 1'b1; address = 2'd2; writedata = 16'h1234;
    run(18, 12, 15, 16'hCAFE, 1, 2'd1, 10);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("C.cs_n@%0d", c), t_cs[c], !(in_rng(c, 1, 8) || in_rng(c, 10, 17)));
      chk($sformatf("C.wr_n@%0d", c), t_wr[c], !in_rng(c, 3, 6));
      chk($sformatf("C.rd_n@%0d", c), t_rd[c], !in_rng(c, 12, 15));
      chk($sformatf("C.oe@%0d", c), t_oe[c], in_rng(c, 1, 8));
      chk($sformatf("C.wait@%0d", c), t_wait[c], c != 9 && c != 18);
      chk($sformatf("C.rdv@%0d", c), t_rdv[c], c == 16);
      chk($sformatf("C.rdata@%0d", c), t_rdata[c], (c >= 16) ? 16'hCAFE : 16'hBEEF);
      if (in_rng(c, 1, 8)) begin
        chk($sformatf("C.addr@%0d", c), t_addr[c], 2'd2);
        chk($sformatf("C.dout@%0d", c), t_dout[c], 16'h1234);
      end
      if (in_rng(c, 10, 17)) chk($sformatf("C.addr@%0d", c), t_addr[c], 2'd1);
    end

    // D: read and write together -> write wins
    read = 1'b1; write = 1'b1; address = 2'd1; writedata = 16'h00FF;
    run(10, 3, 6, 16'h7777, 0, 2'd0, 1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("D.rd_n@%0d", c), t_rd[c], 1'b1);
      chk($sformatf("D.wr_n@%0d", c), t_wr[c], !in_rng(c, 3, 6));
      chk($sformatf("D.rdv@%0d", c), t_rdv[c], 1'b0);
      chk($sformatf("D.oe@%0d", c), t_oe[c], in_rng(c, 1, 8));
      if (in_rng(c, 1, 8)) begin
        chk($sformatf("D.addr@%0d", c), t_addr[c], 2'd1);
        chk($sformatf("D.dout@%0d", c), t_dout[c], 16'h00FF);
      end
    end
    chk("D.rdata", t_rdata[10], 16'hCAFE);

    // E: reset pulse in cycle 4 of a read, then a new read right after release
    read = 1'b1; address = 2'd0;
    run(4, 3, 6, 16'h1111, 0, 2'd0, 1);
    chk("E.rd_n@4", t_rd[4], 1'b0);
    reset = 1'b1; read = 1'b1; address = 2'd3;
    #1;
    chk("E.cs_n.rst", otg_cs_n, 1'b1);
    chk("E.rd_n.rst", otg_rd_n, 1'b1);
    chk("E.wait.rst", waitrequest, 1'b0);
    chk("E.rdata.rst", readdata, 16'h0000);
    #1 reset = 1'b0;
    run(10, 3, 6, 16'h2222, 0, 2'd0, 1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("E.cs_n@%0d", c), t_cs[c], !in_rng(c, 1, 8));
      chk($sformatf("E.rd_n@%0d", c), t_rd[c], !in_rng(c, 3, 6));
      chk($sformatf("E.rdv@%0d", c), t_rdv[c], c == 7);
    end
    chk("E.addr@1", t_addr[1], 2'd3);
    chk("E.rdata@6", t_rdata[6], 16'h0000);
    chk("E.rdata@7", t_rdata[7], 16'h2222);

    // F: S=P=H=1 instance, write held so it is re-accepted at cycle 4
    f_write = 1'b1; f_address = 2'd2; f_writedata = 16'h0F0F;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 5) f_write = 1'b0;
      chk($sformatf("F.cs_n@%0d", c), f_cs_n, !(in_rng(c, 1, 3) || in_rng(c, 5, 7)));
      chk($sformatf("F.wr_n@%0d", c), f_wr_n, !(c == 2 || c == 6));
      chk($sformatf("F.wait@%0d", c), f_waitrequest, !(c == 4 || c == 8));
      chk($sformatf("F.rd_n@%0d", c), f_rd_n, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iwanna_hpi_io_seq.md
IWANNA_HPI_IO_SEQ -- requirements
Module: iwanna_hpi_io_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, HPI address/CS setup cycles before strobe (legal 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4, rd_n/wr_n low cycles (legal 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 2, CS/address/data hold cycles after strobe (legal 1..15).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS).
REQ-007 read  in  1  Avalon-MM read request.
REQ-008 write  in  1  Avalon-MM write request.
REQ-009 writedata  in  16  write data.
REQ-010 waitrequest  out  1  high = request not accepted this cycle.
REQ-011 readdata  out  16  last captured HPI read data.
REQ-012 readdatavalid  out  1  one-cycle pulse, readdata valid.
REQ-013 otg_cs_n  out  1  HPI chip select, active low.
REQ-014 otg_rd_n / otg_wr_n  out  1 each  HPI strobes, active low.
REQ-015 otg_addr  out  2  HPI register address.
REQ-016 otg_data_out  out  16  data driven to HPI bus; otg_data_oe  out  1  tri-state enable (top level builds the bidir pad).
REQ-017 otg_data_in  in  16  data sampled from HPI bus.

Function
REQ-018 FSM states IDLE, SETUP, STROBE, HOLD; single 4-bit phase counter loaded with (phase length - 1), decremented each cycle, phase exits at 0.
REQ-019 waitrequest SHALL equal (state != IDLE); request accepted when state is IDLE and read|write is high.
REQ-020 On accept: latch address, direction, writedata; next state SETUP; write wins if read and write both high (read dropped, no readdatavalid).
REQ-021 With accept in cycle 0: SETUP cycles 1..S, STROBE S+1..S+P, HOLD S+P+1..S+P+H, IDLE at S+P+H+1 (S,P,H = parameters).
REQ-022 All HPI outputs registered and glitch-free; otg_cs_n low exactly during SETUP/STROBE/HOLD; otg_addr stable that whole window.
REQ-023 otg_rd_n (read) or otg_wr_n (write) low exactly during STROBE; never both low.
REQ-024 Write: otg_data_oe high and otg_data_out = latched data during SETUP/STROBE/HOLD; oe low in IDLE and for all reads.
REQ-025 Read: otg_data_in captured on the edge ending the last STROBE cycle; readdata updates then, readdatavalid high for the first HOLD cycle only.
REQ-026 readdata holds its value until the next read capture; writes do not alter it.
REQ-027 Back-to-back requests: request held during occupancy is accepted in the first IDLE cycle; otg_cs_n high at least one cycle between accesses; minimum access period S+P+H+1 cycles.
REQ-028 Requests during waitrequest high SHALL be ignored (no latching of address/data).

Reset
REQ-029 While reset is high: state IDLE, counter 0, otg_cs_n/otg_rd_n/otg_wr_n = 1, otg_data_oe = 0, otg_addr = 0, otg_data_out = 0, readdata = 0, readdatavalid = 0, waitrequest = 0.
REQ-030 Reset mid-access SHALL deassert HPI strobes/CS/oe immediately (asynchronously); the access is abandoned, no readdatavalid after release.

Structure
REQ-031 Package iwanna_hpi_pkg SHALL hold the state enum, HPI register address constants, and phase counter width (4).
REQ-032 Phase counter SHALL be sub-module iwanna_hpi_phase_cnt (load, decrement, zero flag); everything else in iwanna_hpi_io_seq.

Verification
REQ-033 Defaults, write addr 2 data 0x1234 -> cs_n low cycles 1..8, wr_n low 3..6, oe high 1..8 with data 0x1234, waitrequest high 1..8.
REQ-034 Defaults, read addr 0, otg_data_in = 0xBEEF during STROBE -> rd_n low 3..6, readdatavalid pulse cycle 7, readdata = 0xBEEF.
REQ-035 Write then read held asserted -> read accepted cycle 9, cs_n high exactly cycle 9, read strobe cycles 12..15.
REQ-036 read and write both high, addr 1 data 0x00FF -> write cycle performed, rd_n never low, no readdatavalid.
REQ-037 reset pulsed in cycle 4 of a read -> cs_n/rd_n high same cycle, no readdatavalid, next request accepted right after release.
REQ-038 S=P=H=1, write -> cs_n low cycles 1..3, wr_n low cycle 2, next accept possible cycle 4.
